// File: rtl/fxy_scan_ctrl.sv
// Scan sequencer for a two-output combinational function block: walks every
// input vector, captures s1/s2 truth tables and reports whether they agree.
module fxy_scan_ctrl #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   x_out,
  input  logic              s1_in,
  input  logic              s2_in,
  output logic              busy,
  output logic              done,
  output logic              equal,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_bad,
  output logic [(1<<N_IN)-1:0] tt1,
  output logic [(1<<N_IN)-1:0] tt2
);

  localparam int unsigned NVEC  = 1 << N_IN;
  localparam int unsigned IDX_W = N_IN;
  localparam int unsigned CNT_W = N_IN + 1;
  localparam int unsigned SET_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [IDX_W-1:0]   x_out_q, x_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               equal_q, equal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   first_bad_q, first_bad_d;
  logic [NVEC-1:0]    tt1_q, tt1_d;
  logic [NVEC-1:0]    tt2_q, tt2_d;

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      set_q       <= '0;
      x_out_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      equal_q     <= 1'b0;
      cnt_q       <= '0;
      first_bad_q <= '0;
      tt1_q       <= '0;
      tt2_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      set_q       <= set_d;
      x_out_q     <= x_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      equal_q     <= equal_d;
      cnt_q       <= cnt_d;
      first_bad_q <= first_bad_d;
      tt1_q       <= tt1_d;
      tt2_q       <= tt2_d;
    end
  end

  // Next-state logic; output flops are loaded with the value for the next
  // state so they line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    set_d       = set_q;
    equal_d     = equal_q;
    cnt_d       = cnt_q;
    first_bad_d = first_bad_q;
    tt1_d       = tt1_q;
    tt2_d       = tt2_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_DRIVE;
          idx_d       = '0;
          set_d       = '0;
          equal_d     = 1'b0;
          cnt_d       = '0;
          first_bad_d = '0;
          tt1_d       = '0;
          tt2_d       = '0;
        end
      end
      S_DRIVE: begin
        if (set_q == SET_W'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
          set_d   = '0;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      S_SAMPLE: begin
        tt1_d[idx_q] = s1_in;
        tt2_d[idx_q] = s2_in;
        if (s1_in != s2_in) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '0) first_bad_d = idx_q;
        end
        if (idx_q == IDX_W'(NVEC - 1)) begin
          state_d = S_DONE;
          equal_d = (cnt_d == '0);
        end else begin
          state_d = S_DRIVE;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d  = (state_d == S_DONE);
    x_out_d = busy_d ? idx_d : '0;
  end

  assign x_out        = x_out_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign equal        = equal_q;
  assign mismatch_cnt = cnt_q;
  assign first_bad    = first_bad_q;
  assign tt1          = tt1_q;
  assign tt2          = tt2_q;

endmodule
